// File: rtl/if_id_hazard_stage_if.sv
// Bundles the fetch-side inputs, ID/EX feedback and decode-side outputs of the IF/ID stage.
// The master drives fetch and hazard inputs. The slave is the stage itself.
interface if_id_hazard_stage_if #(
  parameter int N     = 32,
  parameter int CNT_W = 16
);
  logic             enable;
  logic [N-1:0]     pc_i;
  logic [N-1:0]     pc4_i;
  logic [N-1:0]     instr_i;
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_rd;
  logic             redirect;
  logic [N-1:0]     pc_o;
  logic [N-1:0]     pc4_o;
  logic [N-1:0]     instr_o;
  logic             valid_o;
  logic             pc_write;
  logic             bubble;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output enable, pc_i, pc4_i, instr_i, id_ex_mem_read, id_ex_rd, redirect,
    input  pc_o, pc4_o, instr_o, valid_o, pc_write, bubble, state_o, stall_cnt, flush_cnt
  );

  modport slave (
    input  enable, pc_i, pc4_i, instr_i, id_ex_mem_read, id_ex_rd, redirect,
    output pc_o, pc4_o, instr_o, valid_o, pc_write, bubble, state_o, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use stall detection, redirect flush sequencing,
// and saturating stall/flush event counters.
module if_id_hazard_stage #(
  parameter int             N         = 32,
  parameter int             FLUSH_CYC = 1,
  parameter int             CNT_W     = 16,
  parameter logic [N-1:0]   NOP       = 'h13
) (
  input logic                 clk,
  input logic                 reset,
  if_id_hazard_stage_if.slave bus
);

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC - 1);

  state_t           state_reg, state_next;
  logic [3:0]       flush_ctr_reg, flush_ctr_next;
  logic [N-1:0]     pc_reg, pc_next;
  logic [N-1:0]     pc4_reg, pc4_next;
  logic [N-1:0]     instr_reg, instr_next;
  logic             valid_reg, valid_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
  logic [1:0]       rs_match;
  logic             hazard;

  // rs1 sits at [19:15], rs2 at [24:20]
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_rs_match
    assign rs_match[gi] = (instr_reg[15 + 5*gi +: 5] == bus.id_ex_rd);
  end

  assign hazard = valid_reg & bus.id_ex_mem_read & (bus.id_ex_rd != 5'd0) & (|rs_match);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= RUN;
      flush_ctr_reg <= 4'd0;
      pc_reg        <= '0;
      pc4_reg       <= '0;
      instr_reg     <= NOP;
      valid_reg     <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_ctr_reg <= flush_ctr_next;
      pc_reg        <= pc_next;
      pc4_reg       <= pc4_next;
      instr_reg     <= instr_next;
      valid_reg     <= valid_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    flush_ctr_next = flush_ctr_reg;
    pc_next        = pc_reg;
    pc4_next       = pc4_reg;
    instr_next     = instr_reg;
    valid_next     = valid_reg;
    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    if (bus.enable) begin
      if (bus.redirect) begin
        state_next     = FLUSH;
        flush_ctr_next = FLUSH_LOAD;
        pc_next        = bus.pc_i;
        pc4_next       = bus.pc4_i;
        instr_next     = NOP;
        valid_next     = 1'b0;
        if (flush_cnt_reg != '1) flush_cnt_next = flush_cnt_reg + 1'b1;
      end else if (hazard) begin
        if (stall_cnt_reg != '1) stall_cnt_next = stall_cnt_reg + 1'b1;
      end else if (state_reg == FLUSH && flush_ctr_reg != 4'd0) begin
        flush_ctr_next = flush_ctr_reg - 4'd1;
        pc_next        = bus.pc_i;
        pc4_next       = bus.pc4_i;
        instr_next     = NOP;
        valid_next     = 1'b0;
      end else begin
        // The edge that leaves FLUSH captures the fetch stream, so invalid time is FLUSH_CYC cycles
        state_next     = RUN;
        pc_next        = bus.pc_i;
        pc4_next       = bus.pc4_i;
        instr_next     = bus.instr_i;
        valid_next     = 1'b1;
      end
    end
  end

  always_comb begin
    bus.pc_write = 1'b0;
    bus.bubble   = 1'b0;
    if (bus.enable) begin
      if (bus.redirect) begin
        bus.pc_write = 1'b1;
        bus.bubble   = 1'b1;
      end else if (hazard) begin
        bus.bubble   = 1'b1;
      end else begin
        bus.pc_write = 1'b1;
      end
    end
  end

  assign bus.pc_o      = pc_reg;
  assign bus.pc4_o     = pc4_reg;
  assign bus.instr_o   = instr_reg;
  assign bus.valid_o   = valid_reg;
  assign bus.state_o   = state_reg;
  assign bus.stall_cnt = stall_cnt_reg;
  assign bus.flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Self-checking bench for if_id_hazard_stage: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model.
module tb_if_id_hazard_stage;
  localparam int N         = 32;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 4;
  localparam logic [31:0] NOP_W = 32'h13;
  localparam logic [31:0] LW_X5 = 32'h0000a283; // lw  x5,0(x1)
  localparam logic [31:0] ADD_6 = 32'h00128333; // add x6,x5,x1
  localparam logic [31:0] ADD_3 = 32'h002081b3; // add x3,x1,x2

  logic clk = 1'b0;
  logic reset;
  int tests_run = 0;
  int tests_failed = 0;

  if_id_hazard_stage_if #(.N(N), .CNT_W(CNT_W)) bus ();

  if_id_hazard_stage #(.N(N), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W), .NOP(NOP_W)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: flush_left counts remaining invalid cycles, including the current one.
  logic [31:0] m_pc, m_pc4, m_instr;
  bit          m_valid;
  int          flush_left;
  int          m_stall, m_flush;

  function automatic bit m_hazard();
    return m_valid && bus.id_ex_mem_read && (bus.id_ex_rd != 5'd0) &&
           (bus.id_ex_rd == m_instr[19:15] || bus.id_ex_rd == m_instr[24:20]);
  endfunction

  function automatic bit exp_pc_write();
    if (!bus.enable) return 1'b0;
    if (bus.redirect) return 1'b1;
    return !m_hazard();
  endfunction

  function automatic bit exp_bubble();
    return bus.enable && (bus.redirect || m_hazard());
  endfunction

  function automatic logic [1:0] exp_state();
    return (flush_left > 0) ? 2'd1 : 2'd0;
  endfunction

  task automatic model_edge();
    bit hz;
    hz = m_hazard();
    if (!reset) begin
      m_pc = 0; m_pc4 = 0; m_instr = NOP_W; m_valid = 0;
      flush_left = 0; m_stall = 0; m_flush = 0;
    end else if (bus.enable) begin
      if (bus.redirect) begin
        m_pc = bus.pc_i; m_pc4 = bus.pc4_i; m_instr = NOP_W; m_valid = 0;
        flush_left = FLUSH_CYC;
        if (m_flush < 15) m_flush++;
      end else if (hz) begin
        if (m_stall < 15) m_stall++;
      end else begin
        if (flush_left > 0) flush_left--;
        m_pc = bus.pc_i; m_pc4 = bus.pc4_i;
        if (flush_left > 0) begin
          m_instr = NOP_W; m_valid = 0;
        end else begin
          m_instr = bus.instr_i; m_valid = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic feed(input logic [31:0] pc, input logic [31:0] instr);
    bus.pc_i = pc; bus.pc4_i = pc + 32'd4; bus.instr_i = instr;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.enable = 1'b1; bus.redirect = 1'b1; bus.id_ex_mem_read = 1'b0; bus.id_ex_rd = 5'd0;
    feed($urandom, $urandom);
    tick(); tick();
    reset = 1'b1; bus.redirect = 1'b0;
    #1;
    tests_run++; if (bus.instr_o !== NOP_W) begin tests_failed++; $display("FAIL reset_instr: got %h want %h", bus.instr_o, NOP_W); end
    tests_run++; if (bus.valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
    tests_run++; if (bus.pc_o !== 32'd0 || bus.pc4_o !== 32'd0) begin tests_failed++; $display("FAIL reset_pc: got %h/%h want 0/0", bus.pc_o, bus.pc4_o); end
    tests_run++; if (bus.state_o !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", bus.state_o); end
    tests_run++; if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt); end
  endtask

  task automatic test_load_use();
    feed(32'h100, LW_X5); tick();
    feed(32'h104, ADD_6); tick();
    bus.id_ex_mem_read = 1'b1; bus.id_ex_rd = 5'd5;
    feed(32'h108, ADD_3); #1;
    tests_run++; if (bus.pc_write !== 1'b0 || bus.bubble !== 1'b1) begin tests_failed++; $display("FAIL lu_ctrl: got pcw=%b bub=%b want pcw=0 bub=1", bus.pc_write, bus.bubble); end
    tick();
    tests_run++; if (bus.instr_o !== ADD_6 || bus.pc_o !== 32'h104) begin tests_failed++; $display("FAIL lu_hold: got %h@%h want %h@104", bus.instr_o, bus.pc_o, ADD_6); end
    tests_run++; if (bus.stall_cnt !== 4'd1) begin tests_failed++; $display("FAIL lu_stall_cnt: got %0d want 1", bus.stall_cnt); end
    bus.id_ex_mem_read = 1'b0; #1;
    tests_run++; if (bus.pc_write !== 1'b1 || bus.bubble !== 1'b0) begin tests_failed++; $display("FAIL lu_release: got pcw=%b bub=%b want pcw=1 bub=0", bus.pc_write, bus.bubble); end
    tick();
    tests_run++; if (bus.instr_o !== ADD_3 || bus.pc4_o !== 32'h10c) begin tests_failed++; $display("FAIL lu_advance: got %h pc4=%h want %h pc4=10c", bus.instr_o, bus.pc4_o, ADD_3); end
  endtask

  task automatic test_rd_zero();
    feed(32'h200, ADD_6); tick();
    bus.id_ex_mem_read = 1'b1; bus.id_ex_rd = 5'd0;
    feed(32'h204, ADD_3); #1;
    tests_run++; if (bus.pc_write !== 1'b1 || bus.bubble !== 1'b0) begin tests_failed++; $display("FAIL rd0_ctrl: got pcw=%b bub=%b want pcw=1 bub=0", bus.pc_write, bus.bubble); end
    tick();
    tests_run++; if (bus.stall_cnt !== 4'd1 || bus.instr_o !== ADD_3) begin tests_failed++; $display("FAIL rd0_noStall: got cnt=%0d instr=%h want cnt=1 instr=%h", bus.stall_cnt, bus.instr_o, ADD_3); end
    bus.id_ex_mem_read = 1'b0;
  endtask

  task automatic test_redirect();
    bus.redirect = 1'b1; feed(32'h300, $urandom); #1;
    tests_run++; if (bus.pc_write !== 1'b1 || bus.bubble !== 1'b1) begin tests_failed++; $display("FAIL rd_ctrl: got pcw=%b bub=%b want 1/1", bus.pc_write, bus.bubble); end
    tick(); bus.redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic want_v;
      logic [1:0] want_s;
      want_v = (k == 2);
      want_s = (k == 2) ? 2'd0 : 2'd1;
      tests_run++; if (bus.valid_o !== want_v || bus.state_o !== want_s) begin tests_failed++; $display("FAIL rd_seq%0d: got v=%b s=%0d want v=%b s=%0d", k, bus.valid_o, bus.state_o, want_v, want_s); end
      feed(32'h304 + 4*k, ADD_6); tick();
    end
    tests_run++; if (bus.flush_cnt !== 4'd1) begin tests_failed++; $display("FAIL rd_flush_cnt: got %0d want 1", bus.flush_cnt); end
    // instr_o is now ADD_6 and valid: hazard and redirect together
    bus.id_ex_mem_read = 1'b1; bus.id_ex_rd = 5'd5; bus.redirect = 1'b1; #1;
    tests_run++; if (bus.pc_write !== 1'b1 || bus.bubble !== 1'b1) begin tests_failed++; $display("FAIL rdhz_ctrl: got pcw=%b bub=%b want 1/1", bus.pc_write, bus.bubble); end
    tick();
    tests_run++; if (bus.stall_cnt !== 4'd1 || bus.flush_cnt !== 4'd2 || bus.state_o !== 2'd1) begin tests_failed++; $display("FAIL rdhz_win: got st=%0d fl=%0d s=%0d want 1/2/1", bus.stall_cnt, bus.flush_cnt, bus.state_o); end
    bus.redirect = 1'b0; bus.id_ex_mem_read = 1'b0;
    tick(); tick();
  endtask

  task automatic test_enable_hold();
    bus.enable = 1'b0; bus.redirect = 1'b1;
    for (int k = 0; k < 3; k++) begin
      feed($urandom, $urandom); #1;
      tests_run++; if (bus.pc_write !== 1'b0 || bus.bubble !== 1'b0) begin tests_failed++; $display("FAIL en_ctrl%0d: got pcw=%b bub=%b want 0/0", k, bus.pc_write, bus.bubble); end
      tick();
      tests_run++; if (bus.instr_o !== m_instr || bus.pc_o !== m_pc || bus.valid_o !== m_valid || bus.state_o !== exp_state() || bus.flush_cnt !== 4'(m_flush)) begin tests_failed++; $display("FAIL en_hold%0d: got %h@%h v=%b s=%0d f=%0d want %h@%h v=%b s=%0d f=%0d", k, bus.instr_o, bus.pc_o, bus.valid_o, bus.state_o, bus.flush_cnt, m_instr, m_pc, m_valid, exp_state(), m_flush); end
    end
    bus.enable = 1'b1; bus.redirect = 1'b0;
  endtask

  task automatic test_saturation();
    feed(32'h400, ADD_6); tick();
    bus.id_ex_mem_read = 1'b1; bus.id_ex_rd = 5'd5;
    for (int k = 0; k < 20; k++) tick();
    tests_run++; if (bus.stall_cnt !== 4'hF || bus.instr_o !== ADD_6) begin tests_failed++; $display("FAIL sat_stall: got cnt=%h instr=%h want F/%h", bus.stall_cnt, bus.instr_o, ADD_6); end
    bus.id_ex_mem_read = 1'b0;
  endtask

  task automatic test_reset_mid_flush();
    bus.redirect = 1'b1; tick(); bus.redirect = 1'b0;
    tests_run++; if (bus.state_o !== 2'd1) begin tests_failed++; $display("FAIL rmf_pre: got s=%0d want 1", bus.state_o); end
    reset = 1'b0; tick(); reset = 1'b1;
    tests_run++; if (bus.state_o !== 2'd0 || bus.valid_o !== 1'b0 || bus.instr_o !== NOP_W || bus.pc_o !== 32'd0 || bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin tests_failed++; $display("FAIL rmf_post: got s=%0d v=%b i=%h pc=%h st=%0d fl=%0d want all reset", bus.state_o, bus.valid_o, bus.instr_o, bus.pc_o, bus.stall_cnt, bus.flush_cnt); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(63) != 0);
      bus.enable = ($urandom_range(7) != 0);
      bus.redirect = ($urandom_range(7) == 0);
      bus.id_ex_mem_read = $urandom_range(1);
      bus.id_ex_rd = 5'($urandom_range(3));
      ins = $urandom;
      if ($urandom_range(1)) ins[19:15] = 5'($urandom_range(3));
      if ($urandom_range(1)) ins[24:20] = 5'($urandom_range(3));
      feed($urandom, ins); #1;
      tests_run++; if (bus.pc_write !== exp_pc_write() || bus.bubble !== exp_bubble()) begin tests_failed++; $display("FAIL rand_ctrl c%0d: got pcw=%b bub=%b want %b/%b", c, bus.pc_write, bus.bubble, exp_pc_write(), exp_bubble()); end
      tick();
      tests_run++; if (bus.instr_o !== m_instr || bus.pc_o !== m_pc || bus.pc4_o !== m_pc4 || bus.valid_o !== m_valid) begin tests_failed++; $display("FAIL rand_data c%0d: got %h@%h/%h v=%b want %h@%h/%h v=%b", c, bus.instr_o, bus.pc_o, bus.pc4_o, bus.valid_o, m_instr, m_pc, m_pc4, m_valid); end
      tests_run++; if (bus.state_o !== exp_state() || bus.stall_cnt !== 4'(m_stall) || bus.flush_cnt !== 4'(m_flush)) begin tests_failed++; $display("FAIL rand_state c%0d: got s=%0d st=%0d fl=%0d want s=%0d st=%0d fl=%0d", c, bus.state_o, bus.stall_cnt, bus.flush_cnt, exp_state(), m_stall, m_flush); end
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.enable = 1'b1; bus.redirect = 1'b0; bus.id_ex_mem_read = 1'b0; bus.id_ex_rd = 5'd0;
    feed(32'd0, NOP_W);
    m_pc = 0; m_pc4 = 0; m_instr = NOP_W; m_valid = 0; flush_left = 0; m_stall = 0; m_flush = 0;
    #2;
    test_reset();
    test_load_use();
    test_rd_zero();
    test_redirect();
    test_enable_hold();
    test_saturation();
    test_reset_mid_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
